// File: rtl/nrs_est_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nrs_est_pkg
// Description : Shared constants and helper for the NRS least-squares
//               estimator: default datapath widths, the 1/sqrt(2) constant,
//               the rounding constant and the sign-select add/sub helper.
// Revision    : 1.0 - initial release
// ============================================================================
package nrs_est_pkg;

   localparam int          NRS_WIDTH = 16;
   localparam int          NRS_FRAC  = 11;
   localparam logic [10:0] NRS_K     = 11'b10110101000;   // 1448/2048
   localparam int          NRS_ROUND = 1 << (NRS_FRAC - 1);

   // Working width of the add/sub helper; callers sign-extend into it and
   // truncate the result back to their own width.
   localparam int          SA_W      = 32;

   // (neg_a ? -a : a) + (neg_b ? -b : b): multiplying by +/-1 reduces to a
   // conditional negate, so no multiplier is needed.
   function automatic logic signed [SA_W-1:0] sign_add(
      input logic                   neg_a,
      input logic signed [SA_W-1:0] a,
      input logic                   neg_b,
      input logic signed [SA_W-1:0] b
   );
      logic signed [SA_W-1:0] ta;
      logic signed [SA_W-1:0] tb;
      ta = neg_a ? -a : a;
      tb = neg_b ? -b : b;
      return ta + tb;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nrs_pingpong_buf.sv
`default_nettype none
// ============================================================================
// Module      : nrs_pingpong_buf
// Description : Two-bank estimate store. One write port, one registered read
//               port into the read bank, per-bank reserved/full flags and the
//               read-bank pointer. With NRS_SYM_AVG_EN defined an extra
//               combinational read port supplies the old value for the
//               averaging read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module nrs_pingpong_buf #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic                  wr_bank,
   input  logic [AW-1:0]         wr_addr,
   input  logic signed [WIDTH:0] wr_data_r,
   input  logic signed [WIDTH:0] wr_data_i,
   input  logic                  wr_last,
   input  logic                  rsv_set,
   input  logic                  rsv_bank,
   output logic [1:0]            reserved,
`ifdef NRS_SYM_AVG_EN
   input  logic                  old_bank,
   input  logic [AW-1:0]         old_addr,
   output logic signed [WIDTH:0] old_r,
   output logic signed [WIDTH:0] old_i,
`endif
   input  logic [AW-1:0]         rd_addr,
   input  logic                  rd_done,
   output logic                  est_valid,
   output logic signed [WIDTH:0] rd_data_r,
   output logic signed [WIDTH:0] rd_data_i
);

   logic signed [WIDTH:0] mem_r [2*DEPTH];
   logic signed [WIDTH:0] mem_i [2*DEPTH];
   logic [1:0]            full;
   logic                  rd_bank;
   logic [1:0]            clr_mask;
   logic [1:0]            rsv_mask;
   logic [1:0]            full_mask;

   assign est_valid = full[rd_bank];

`ifdef NRS_SYM_AVG_EN
   assign old_r = mem_r[{old_bank, old_addr}];
   assign old_i = mem_i[{old_bank, old_addr}];
`endif

   // Storage: cleared only by reset, written from the end of the pipeline.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 2*DEPTH; k++) begin
            mem_r[k] <= '0;
            mem_i[k] <= '0;
         end
      end else if (wr_en) begin
         mem_r[{wr_bank, wr_addr}] <= wr_data_r;
         mem_i[{wr_bank, wr_addr}] <= wr_data_i;
      end
   end

   // Registered read port; flush leaves the last read value in place.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data_r <= '0;
         rd_data_i <= '0;
      end else begin
         rd_data_r <= mem_r[{rd_bank, rd_addr}];
         rd_data_i <= mem_i[{rd_bank, rd_addr}];
      end
   end

   // Per-bank set/clear requests; a release only counts while the bank is full.
   always_comb begin
      clr_mask  = '0;
      rsv_mask  = '0;
      full_mask = '0;
      if (rd_done && full[rd_bank]) clr_mask[rd_bank]  = 1'b1;
      if (rsv_set)                  rsv_mask[rsv_bank] = 1'b1;
      if (wr_en && wr_last)         full_mask[wr_bank] = 1'b1;
   end

   // Bank flags and read pointer; both banks update independently so a
   // release and a completion on opposite banks in one cycle both land.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reserved <= '0;
         full     <= '0;
         rd_bank  <= 1'b0;
      end else if (flush) begin
         reserved <= '0;
         full     <= '0;
         rd_bank  <= 1'b0;
      end else begin
         reserved <= (reserved & ~clr_mask) | rsv_mask;
         full     <= (full & ~clr_mask) | full_mask;
         if (clr_mask != 2'b00) rd_bank <= !rd_bank;
      end
   end

endmodule
`default_nettype wire

// File: rtl/nrs_ls_estimator.sv
`default_nettype none
// ============================================================================
// Module      : nrs_ls_estimator
// Description : Pipelined LS channel estimator for NB-IoT NRS pilots.
//               est = round(rx * conj(nrs)), nrs components +/-1/sqrt(2),
//               stored into a ping-pong buffer of DEPTH estimates per bank.
//               Optional build macro NRS_SYM_AVG_EN: two-symbol averaging,
//               each bank takes two passes and stores the rounded mean.
// Revision    : 1.0 - initial release
// ============================================================================
module nrs_ls_estimator
   import nrs_est_pkg::*;
#(
   parameter int              WIDTH = NRS_WIDTH,
   parameter int              FRAC  = NRS_FRAC,
   parameter logic [FRAC-1:0] K     = NRS_K,
   parameter int              DEPTH = 4,
   localparam int             AW    = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] rx_r,
   input  logic signed [WIDTH-1:0] rx_i,
   input  logic                    nrs_r,
   input  logic                    nrs_i,
   output logic                    est_valid,
   input  logic [AW-1:0]           rd_addr,
   output logic signed [WIDTH:0]   rd_data_r,
   output logic signed [WIDTH:0]   rd_data_i,
   input  logic                    rd_done
);

   localparam int                   EW       = WIDTH + 1;
   localparam int                   PW       = WIDTH + FRAC + 2;
   localparam logic [AW-1:0]        LAST_IDX = AW'(DEPTH - 1);
   localparam logic signed [PW-1:0] ROUND    = PW'(1) << (FRAC - 1);

   logic                 accept;
   logic                 cnt_last;
   logic                 bank_done;
   logic [AW-1:0]        in_cnt;
   logic                 in_bank;
   logic [1:0]           reserved;
   logic signed [EW-1:0] sum_r_w;
   logic signed [EW-1:0] sum_i_w;
   logic signed [PW-1:0] k_ext;
   logic signed [EW-1:0] est_r_w;
   logic signed [EW-1:0] est_i_w;
   logic                 s1_valid;
   logic signed [EW-1:0] s1_sum_r;
   logic signed [EW-1:0] s1_sum_i;
   logic [AW-1:0]        s1_addr;
   logic                 s1_bank;
   logic                 s2_valid;
   logic signed [EW-1:0] s2_est_r;
   logic signed [EW-1:0] s2_est_i;
   logic [AW-1:0]        s2_addr;
   logic                 s2_bank;
   logic signed [EW-1:0] wr_data_r;
   logic signed [EW-1:0] wr_data_i;
   logic                 wr_last;
   logic                 wr_en;

   assign in_ready = !reserved[in_bank];
   assign accept   = in_valid && in_ready && !flush;
   assign cnt_last = (in_cnt == LAST_IDX);
   assign wr_en    = s2_valid && !flush;

`ifdef NRS_SYM_AVG_EN
   localparam int AVW = WIDTH + 2;

   logic [1:0]           pass;
   logic                 s1_pass;
   logic                 s2_pass;
   logic signed [EW-1:0] old_r;
   logic signed [EW-1:0] old_i;
   logic signed [EW-1:0] s2_old_r;
   logic signed [EW-1:0] s2_old_i;
   logic signed [AVW-1:0] avg_r;
   logic signed [AVW-1:0] avg_i;

   // A bank is handed over only after its second pass.
   assign bank_done = cnt_last && pass[in_bank];
   assign wr_last   = (s2_addr == LAST_IDX) && s2_pass;

   // Pass bit per bank flips each time that bank's index counter wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass <= '0;
      end else if (flush) begin
         pass <= '0;
      end else if (accept && cnt_last) begin
         pass[in_bank] <= !pass[in_bank];
      end
   end

   // Averaging in one extra bit so the +1 rounding term cannot overflow.
   always_comb begin
      avg_r     = (AVW'(s2_old_r) + AVW'(s2_est_r) + AVW'(1)) >>> 1;
      avg_i     = (AVW'(s2_old_i) + AVW'(s2_est_i) + AVW'(1)) >>> 1;
      wr_data_r = s2_pass ? EW'(avg_r) : s2_est_r;
      wr_data_i = s2_pass ? EW'(avg_i) : s2_est_i;
   end

   // Side registers carrying the pass flag and the old word through the pipe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_pass  <= 1'b0;
         s2_pass  <= 1'b0;
         s2_old_r <= '0;
         s2_old_i <= '0;
      end else begin
         if (accept) s1_pass <= pass[in_bank];
         s2_pass  <= s1_pass;
         s2_old_r <= old_r;
         s2_old_i <= old_i;
      end
   end
`else
   assign bank_done = cnt_last;
   assign wr_last   = (s2_addr == LAST_IDX);
   assign wr_data_r = s2_est_r;
   assign wr_data_i = s2_est_i;
`endif

   // Write index / bank tracking; DEPTH is a power of two so in_cnt wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_cnt  <= '0;
         in_bank <= 1'b0;
      end else if (flush) begin
         in_cnt  <= '0;
         in_bank <= 1'b0;
      end else if (accept) begin
         in_cnt <= in_cnt + AW'(1);
         if (bank_done) in_bank <= !in_bank;
      end
   end

   // Conjugate product with +/-1 signs, then scale by K with round-half-up.
   always_comb begin
      sum_r_w = EW'(sign_add(nrs_r, SA_W'(rx_r), nrs_i, SA_W'(rx_i)));
      sum_i_w = EW'(sign_add(nrs_r, SA_W'(rx_i), !nrs_i, SA_W'(rx_r)));
      k_ext   = PW'($signed({1'b0, K}));
      est_r_w = EW'((PW'(s1_sum_r) * k_ext + ROUND) >>> FRAC);
      est_i_w = EW'((PW'(s1_sum_i) * k_ext + ROUND) >>> FRAC);
   end

   // Two-stage pipeline: S1 holds the sums, S2 holds the rounded estimate.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_sum_r <= '0;
         s1_sum_i <= '0;
         s1_addr  <= '0;
         s1_bank  <= 1'b0;
         s2_valid <= 1'b0;
         s2_est_r <= '0;
         s2_est_i <= '0;
         s2_addr  <= '0;
         s2_bank  <= 1'b0;
      end else begin
         s1_valid <= accept;
         s2_valid <= s1_valid && !flush;
         if (accept) begin
            s1_sum_r <= sum_r_w;
            s1_sum_i <= sum_i_w;
            s1_addr  <= in_cnt;
            s1_bank  <= in_bank;
         end
         s2_est_r <= est_r_w;
         s2_est_i <= est_i_w;
         s2_addr  <= s1_addr;
         s2_bank  <= s1_bank;
      end
   end

   nrs_pingpong_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .wr_en     (wr_en),
      .wr_bank   (s2_bank),
      .wr_addr   (s2_addr),
      .wr_data_r (wr_data_r),
      .wr_data_i (wr_data_i),
      .wr_last   (wr_last),
      .rsv_set   (accept && bank_done),
      .rsv_bank  (in_bank),
      .reserved  (reserved),
`ifdef NRS_SYM_AVG_EN
      .old_bank  (s1_bank),
      .old_addr  (s1_addr),
      .old_r     (old_r),
      .old_i     (old_i),
`endif
      .rd_addr   (rd_addr),
      .rd_done   (rd_done),
      .est_valid (est_valid),
      .rd_data_r (rd_data_r),
      .rd_data_i (rd_data_i)
   );

endmodule
`default_nettype wire

// File: tb/tb_nrs_ls_estimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_nrs_ls_estimator
// Description : Directed self-checking bench for nrs_ls_estimator. Expected
//               estimates come from a reference model and are queued when a
//               sample is driven, then popped as each bank is read back.
//               Build macro NRS_SYM_AVG_EN selects the averaging sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nrs_ls_estimator;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct packed {
      logic signed [63:0] r;
      logic signed [63:0] i;
   } pair_t;

   logic                    clk      = 1'b0;
   logic                    rst      = 1'b0;
   logic                    flush    = 1'b0;
   logic                    in_valid = 1'b0;
   logic signed [WIDTH-1:0] rx_r     = '0;
   logic signed [WIDTH-1:0] rx_i     = '0;
   logic                    nrs_r    = 1'b0;
   logic                    nrs_i    = 1'b0;
   logic [AW-1:0]           rd_addr  = '0;
   logic                    rd_done  = 1'b0;
   logic                    in_ready;
   logic                    est_valid;
   logic signed [WIDTH:0]   rd_data_r;
   logic signed [WIDTH:0]   rd_data_i;

   int    checks = 0;
   int    errors = 0;
   pair_t exp_q[$];

   always #5 clk = ~clk;

   nrs_ls_estimator dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .rx_r      (rx_r),
      .rx_i      (rx_i),
      .nrs_r     (nrs_r),
      .nrs_i     (nrs_i),
      .est_valid (est_valid),
      .rd_addr   (rd_addr),
      .rd_data_r (rd_data_r),
      .rd_data_i (rd_data_i),
      .rd_done   (rd_done)
   );

   // Reference: sum = rx * conj(sign), est = (sum*1448 + 1024) >>> 11
   function automatic pair_t model(input longint rr, input longint ri,
                                   input bit nr, input bit ni);
      longint sr, si, sum_r, sum_i;
      pair_t  p;
      sr    = nr ? -1 : 1;
      si    = ni ? -1 : 1;
      sum_r = sr * rr + si * ri;
      sum_i = sr * ri - si * rr;
      p.r   = (sum_r * 1448 + 1024) >>> 11;
      p.i   = (sum_i * 1448 + 1024) >>> 11;
      return p;
   endfunction

   task automatic chk(input string tag, input longint obs, input longint expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input longint rr, input longint ri,
                       input bit nr, input bit ni, input bit push);
      chk("send_ready", in_ready, 1);
      rx_r     = WIDTH'(rr);
      rx_i     = WIDTH'(ri);
      nrs_r    = nr;
      nrs_i    = ni;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      if (push) exp_q.push_back(model(rr, ri, nr, ni));
   endtask

   task automatic read_bank(input string tag);
      pair_t e;
      for (int a = 0; a < DEPTH; a++) begin
         rd_addr = AW'(a);
         tick();
         chk({tag, "_queue"}, longint'(exp_q.size() > 0), 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_r"}, rd_data_r, e.r);
            chk({tag, "_i"}, rd_data_i, e.i);
         end
      end
   endtask

   task automatic release_bank();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pair_t e_val, f_val;

      // Reset values while held and right after release
      tick();
      tick();
      chk("rst_est_valid", est_valid, 0);
      chk("rst_rd_data_r", rd_data_r, 0);
      chk("rst_rd_data_i", rd_data_i, 0);
      rst = 1'b1;
      tick();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_est_valid_after", est_valid, 0);

`ifdef NRS_SYM_AVG_EN
      begin
         pair_t p1 [DEPTH];
         pair_t p2 [DEPTH];
         pair_t a;
         p1[0] = model(1000, 0, 0, 0);
         p2[0] = model(1003, 0, 0, 0);
         send(1000, 0, 0, 0, 0);
         for (int k = 1; k < DEPTH; k++) begin
            p1[k] = model(100 * k, -50 * k, k[0], 0);
            send(100 * k, -50 * k, k[0], 0, 0);
         end
         tick(); tick(); tick();
         chk("avg_not_full_pass1", est_valid, 0);
         send(1003, 0, 0, 0, 0);
         for (int k = 1; k < DEPTH; k++) begin
            p2[k] = model(-200 * k, 30, 0, 1);
            send(-200 * k, 30, 0, 1, 0);
         end
         tick();
         chk("avg_full_early", est_valid, 0);
         tick();
         chk("avg_full", est_valid, 1);
         for (int k = 0; k < DEPTH; k++) begin
            a.r = (p1[k].r + p2[k].r + 1) >>> 1;
            a.i = (p1[k].i + p2[k].i + 1) >>> 1;
            exp_q.push_back(a);
         end
         read_bank("avg");
      end
`else
      // Write latency: index 0 of bank 0 lands 2 cycles after acceptance
      rd_addr = '0;
      send(1000, 0, 0, 0, 1);
      tick();
      tick();
      chk("wr_latency_early", rd_data_r, 0);
      tick();
      chk("wr_latency_r", rd_data_r, 707);
      chk("wr_latency_i", rd_data_i, -707);

      // Fill bank 0: sign variants and the negative extreme
      send(1000, 0, 1, 1, 1);
      send(1000, 0, 0, 1, 1);
      send(-32768, -32768, 0, 0, 1);
      chk("est_valid_s1", est_valid, 0);
      tick();
      chk("est_valid_s2", est_valid, 0);
      tick();
      chk("est_valid_rise", est_valid, 1);

      // Fill bank 1 without releasing bank 0: back-pressure
      e_val = model(1, 0, 0, 0);
      f_val = model(0, 1000, 0, 0);
      send(1, 0, 0, 0, 1);
      send(0, 1000, 0, 0, 1);
      send(-1000, 500, 1, 0, 1);
      send(12345, -7000, 1, 1, 1);
      chk("ready_drop", in_ready, 0);
      rx_r     = 16'sd999;
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      chk("ready_held", in_ready, 0);
      chk("bank0_still_valid", est_valid, 1);

      read_bank("bank0");
      release_bank();
      chk("ready_after_done", in_ready, 1);
      chk("bank1_valid", est_valid, 1);
      read_bank("bank1");

      // Collision: release bank 1 on the cycle bank 0 completes
      send(2000, -3000, 0, 1, 1);
      send(-500, -500, 1, 0, 1);
      send(32767, 32767, 0, 0, 1);
      send(-32768, 32767, 1, 1, 1);
      tick();
      rd_done = 1'b1;
      tick();
      rd_done = 1'b0;
      chk("collision_est_valid", est_valid, 1);
      chk("collision_ready", in_ready, 1);
      read_bank("collision");
      release_bank();
      chk("after_release_empty", est_valid, 0);

      // Flush with two samples in flight and an accept attempt in the same cycle
      send(111, 222, 0, 0, 0);
      send(333, 444, 1, 0, 0);
      flush    = 1'b1;
      rx_r     = 16'sd555;
      in_valid = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      tick(); tick(); tick();
      chk("flush_est_valid", est_valid, 0);
      chk("flush_in_ready", in_ready, 1);

      // Counters restart at bank 0 index 0
      send(-7, 9, 0, 1, 1);
      send(4000, 4000, 1, 0, 1);
      send(-16000, 123, 1, 1, 1);
      send(32767, -32768, 0, 0, 1);
      tick(); tick();
      chk("post_flush_valid", est_valid, 1);
      read_bank("post_flush");

      // Bank 1 still holds its pre-flush words: the flushed samples never wrote
      release_bank();
      rd_addr = 2'd0;
      tick();
      chk("no_write_idx0_r", rd_data_r, e_val.r);
      chk("no_write_idx0_i", rd_data_i, e_val.i);
      rd_addr = 2'd1;
      tick();
      chk("no_write_idx1_r", rd_data_r, f_val.r);
      chk("no_write_idx1_i", rd_data_i, f_val.i);
`endif

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/nrs_ls_estimator.md
Name: nrs_ls_estimator

Overview:
- Pipelined least-squares channel estimator for NB-IoT NRS pilots. Computes rx·conj(nrs) per pilot RE, where each NRS component is ±1/√2 and is given by its sign bit only.
- Writes DEPTH estimates per bank into a ping-pong buffer, so the downstream interpolator reads one completed bank while the next one fills.
- Sits between the RE demapper and the channel interpolator/equalizer.

Parameters:
- WIDTH, 16: signed width of rx_r/rx_i.
- FRAC, 11: fractional bits of K.
- K, 11'b10110101000: unsigned constant 1/√2 (1448/2048).
- DEPTH, 4: estimates per bank (pilots per slot per port). Must be a power of two, ≥2.
- AW, $clog2(DEPTH): localparam, read address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of counters, bank flags and pipeline valids
- in_valid  in  1  pilot sample valid
- in_ready  out  1  estimator can accept a sample
- rx_r, rx_i  in  WIDTH  signed received pilot RE
- nrs_r, nrs_i  in  1  NRS sign bits (0 = +1/√2, 1 = −1/√2)
- est_valid  out  1  read bank holds DEPTH valid estimates
- rd_addr  in  AW  read index into the read bank
- rd_data_r, rd_data_i  out  WIDTH+1  signed estimate, registered
- rd_done  in  1  consumer releases the read bank

Behaviour:
- Arithmetic: sr = nrs_r ? −1 : +1, si likewise for nrs_i.
  - sum_r = sr·rx_r + si·rx_i; sum_i = sr·rx_i − si·rx_r. Both are signed WIDTH+1; form them by sign-extended add/sub, no multiplier.
  - est = (sum·K + 2^(FRAC−1)) >>> FRAC, i.e. round-half-up.
  - The result always fits WIDTH+1, so no saturation logic is required.
- Pipeline: a sample is accepted when in_valid && in_ready.
  - S1 registers sum_r/sum_i, address and bank index.
  - S2 registers the rounded product.
  - The write to the buffer occurs at the end of S2, 2 cycles after acceptance.
- Counters:
  - in_cnt (AW bits) and in_bank track acceptance.
  - Accepting the sample with in_cnt == DEPTH−1 sets reserved[in_bank], wraps in_cnt to 0 and toggles in_bank.
  - in_ready = !reserved[in_bank]. in_ready is combinational from registers only, never from in_valid.
- The write that completes a bank (write index DEPTH−1) sets full[bank].
- Reader side:
  - est_valid = full[rd_bank].
  - rd_data updates 1 cycle after rd_addr from bank rd_bank.
  - rd_done while est_valid clears full[rd_bank] and reserved[rd_bank], and toggles rd_bank.
  - rd_done while !est_valid is ignored.
- Simultaneous events:
  - rd_done and the bank-completing write to the other bank in the same cycle: both take effect.
  - rd_done freeing the bank that in_bank points to: in_ready rises the next cycle.
- flush:
  - Zeroes in_cnt, in_bank, rd_bank, reserved, full and the S1/S2 valids.
  - In-flight samples are discarded.
  - Memory contents and rd_data are unchanged.
  - flush has priority over same-cycle accept and rd_done.
- Reset, asynchronous:
  - All counters, flags and pipeline registers go to 0, and so do all memory words.
  - rd_data_r/i = 0, est_valid = 0.
  - in_ready = 1 from the first cycle after rst deasserts.

Optional Feature:
- NRS_SYM_AVG_EN: two-symbol averaging.
- When defined:
  - Each bank takes 2·DEPTH samples. The first DEPTH are written as above.
  - The second DEPTH read-modify-write: new = (old + est + 1) >>> 1, computed in WIDTH+2 bits and stored in WIDTH+1.
  - The old value is read in S1 for the same index.
  - Pass tracking uses one extra bit per bank. reserved and full are set only at the end of the second pass.
- When undefined: single-pass behaviour exactly as above; no extra adder and no pass bit.

Decomposition:
- Package nrs_est_pkg holds:
  - the default WIDTH, FRAC and K localparams;
  - the rounding constant;
  - a function for sign-select add/sub.
- Sub-module nrs_pingpong_buf: 2×DEPTH dual-bank memory, write port, registered read port and full/reserved flags.
- Arithmetic pipeline and counters stay in the top module.

Test Plan:
- Basic conjugate: rx = (1000, 0), nrs = (0, 0) → est (707, −707), written 2 cycles after acceptance.
- Sign variants: rx = (1000, 0) with nrs = (1, 1) → (−707, 707); with nrs = (0, 1) → (707, 707).
- Extremes and rounding:
  - rx = (−32768, −32768), nrs = (0, 0) → (−46336, 0).
  - rx = (1, 0), nrs = (0, 0) → (1, −1).
- Backpressure: feed 2·DEPTH = 8 samples with no rd_done.
  - in_ready drops after the 8th accept.
  - est_valid rises 2 cycles after the 4th accept.
  - After one rd_done, in_ready is high next cycle and rd_bank points to bank 1.
- Collision and flush:
  - rd_done coincident with the completing write of the other bank → est_valid stays high and shows the new bank.
  - flush with 2 samples in flight → est_valid = 0, in_ready = 1, no later write.
- NRS_SYM_AVG_EN: index 0 gets est 707, then 709 on the second pass → stored 708. full is set only after the 8th sample.
